// File: rtl/bin_dn_cnt_reload.sv
// bin_dn_cnt_reload: down counter with parallel load, one-shot/auto-reload terminal count and borrow-out
module bin_dn_cnt_reload #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ld_i,
   input  logic             cnt_i,
   input  logic             mode_i,
   output logic [WIDTH-1:0] A_cnt_o,
   output logic             B_o,
   output logic             tc_o,
   output logic             busy_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_n;
   logic [WIDTH-1:0] cnt_q, cnt_n, reload_q, reload_n;
   logic tc_n;
   logic zero;
   assign zero = (cnt_q == '0);
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         tc_o     <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         reload_q <= reload_n;
         tc_o     <= tc_n;
      end
   end
   // terminal edge in RUN: reload or park in DONE depending on mode_i at that edge
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      reload_n = reload_q;
      tc_n     = 1'b0;
      if (ld_i) begin
         cnt_n    = data_i;
         reload_n = data_i;
         state_n  = RUN;
      end else if (cnt_i) begin
         if (state_q == IDLE) begin
            cnt_n = cnt_q - 1'b1;
         end else if (state_q == RUN) begin
            if (zero) begin
               tc_n    = 1'b1;
               cnt_n   = mode_i ? reload_q : cnt_q;
               state_n = mode_i ? RUN : DONE;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
      end
   end
   assign A_cnt_o = cnt_q;
   assign B_o     = cnt_i & ~ld_i & zero & (state_q != DONE);
   assign busy_o  = (state_q == RUN);
endmodule

// File: tb/tb_bin_dn_cnt_reload.sv
// tb_bin_dn_cnt_reload: directed vectors with hand-computed expectations for bin_dn_cnt_reload
module tb_bin_dn_cnt_reload;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [3:0] data_i = '0;
   logic       ld_i = 1'b0;
   logic       cnt_i = 1'b0;
   logic       mode_i = 1'b0;
   logic [3:0] A_cnt_o;
   logic       B_o, tc_o, busy_o;
   int n_chk = 0;
   int n_fail = 0;

   bin_dn_cnt_reload #(.WIDTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .ld_i(ld_i),
      .cnt_i(cnt_i), .mode_i(mode_i), .A_cnt_o(A_cnt_o), .B_o(B_o),
      .tc_o(tc_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_out(input string tag, input int cnt, input int tc, input int busy);
      check({tag, "_cnt"}, 32'(A_cnt_o), 32'(cnt));
      check({tag, "_tc"}, 32'(tc_o), 32'(tc));
      check({tag, "_busy"}, 32'(busy_o), 32'(busy));
   endtask

   initial begin
      // reset
      step();
      expect_out("rst", 0, 0, 0);
      rst_i = 1'b1;
      // free-running IDLE count with wrap
      cnt_i = 1'b1;
      #1 check("idle_b", 32'(B_o), 1);
      step(); expect_out("idle1", 15, 0, 0);
      step(); expect_out("idle2", 14, 0, 0);
      step(); expect_out("idle3", 13, 0, 0);
      // one-shot load 3
      ld_i = 1'b1; data_i = 4'd3; mode_i = 1'b0;
      step(); expect_out("os_ld", 3, 0, 1);
      ld_i = 1'b0;
      step(); expect_out("os2", 2, 0, 1);
      step(); expect_out("os1", 1, 0, 1);
      step(); expect_out("os0", 0, 0, 1);
      check("os_b0", 32'(B_o), 1);
      step(); expect_out("os_tc", 0, 1, 0);
      check("done_b", 32'(B_o), 0);
      step(); expect_out("done_hold", 0, 0, 0);
      // auto-reload load 2
      ld_i = 1'b1; data_i = 4'd2; mode_i = 1'b1;
      step(); expect_out("ar_ld", 2, 0, 1);
      ld_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int e;
         e = (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2;
         step();
         expect_out("ar", e, (e == 2) ? 1 : 0, 1);
      end
      // load colliding with terminal condition
      check("ar_at0", 32'(A_cnt_o), 0);
      ld_i = 1'b1; data_i = 4'd5;
      #1 check("coll_b", 32'(B_o), 0);
      step(); expect_out("coll", 5, 0, 1);
      // reset overrides load mid-count
      data_i = 4'd9;
      step(); expect_out("r_ld", 9, 0, 1);
      ld_i = 1'b0;
      step(); expect_out("r8", 8, 0, 1);
      step(); expect_out("r7", 7, 0, 1);
      rst_i = 1'b0; ld_i = 1'b1;
      step(); expect_out("r_abort", 0, 0, 0);
      rst_i = 1'b1; ld_i = 1'b0; cnt_i = 1'b0;
      step(); expect_out("r_hold", 0, 0, 0);
      // gated counting
      ld_i = 1'b1; data_i = 4'd4; cnt_i = 1'b1;
      step(); expect_out("g_ld", 4, 0, 1);
      ld_i = 1'b0;
      cnt_i = 1'b1; step(); expect_out("g1", 3, 0, 1);
      cnt_i = 1'b0; step(); expect_out("g2", 3, 0, 1);
      cnt_i = 1'b1; step(); expect_out("g3", 2, 0, 1);
      cnt_i = 1'b0; step(); expect_out("g4", 2, 0, 1);
      // load of 0, one-shot: first enabled edge is terminal
      ld_i = 1'b1; data_i = 4'd0; mode_i = 1'b0;
      step(); expect_out("z_ld", 0, 0, 1);
      ld_i = 1'b0; cnt_i = 1'b1;
      step(); expect_out("z_tc", 0, 1, 0);
      step(); expect_out("z_done", 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
